// File: rtl/gate_probe_pkg.sv
// Shared types and constants for the gate_probe truth-table sweeper.
package gate_probe_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int CNT_W      = 4;
   localparam int N_IN_MIN   = 1;
   localparam int N_IN_MAX   = 4;
   localparam int SETTLE_MIN = 1;
   localparam int SETTLE_MAX = 15;

endpackage

// File: rtl/gate_probe_settle.sv
// Settle timer: counts cycles while enabled, flags the last settle cycle.
module gate_probe_settle
   import gate_probe_pkg::*;
#(
   parameter int SETTLE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic expire
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign expire = (r_cnt == CNT_LAST);

endmodule

// File: rtl/gate_probe.sv
// Drives every input vector to a gate, captures its output into tt.
// Optional GATE_PROBE_CHECK_EN adds an expected-table compare (mismatch).
module gate_probe
   import gate_probe_pkg::*;
#(
   parameter int N_IN   = 2,
   parameter int SETTLE = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 dut_s,
`ifdef GATE_PROBE_CHECK_EN
   input  logic [2**N_IN-1:0]   expected,
   output logic                 mismatch,
`endif
   output logic [N_IN-1:0]      dut_in,
   output logic                 busy,
   output logic                 done,
   output logic [2**N_IN-1:0]   tt
);

   localparam int             NV       = 2**N_IN;
   localparam logic [N_IN-1:0] IDX_LAST = '1;

   state_t            r_state;
   logic [N_IN-1:0]   r_idx;
   logic [N_IN-1:0]   w_idx_nxt;
   logic              w_clear;
   logic              w_expire;
   logic [NV-1:0]     w_tt_final;

   // Timer runs only while a vector is being held; any other state parks it at 0.
   assign w_clear   = (r_state != DRIVE);
   assign w_idx_nxt = r_idx + N_IN'(1);

   gate_probe_settle #(
      .SETTLE (SETTLE)
   ) u_settle (
      .clk    (clk),
      .rst    (rst),
      .clear  (w_clear),
      .expire (w_expire)
   );

   // Table including the sample being taken this cycle, so DONE-entry compare sees it.
   always_comb begin
      w_tt_final        = tt;
      w_tt_final[r_idx] = dut_s;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_idx    <= '0;
         dut_in   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         tt       <= '0;
`ifdef GATE_PROBE_CHECK_EN
         mismatch <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  r_state  <= DRIVE;
                  r_idx    <= '0;
                  dut_in   <= '0;
                  busy     <= 1'b1;
                  tt       <= '0;
`ifdef GATE_PROBE_CHECK_EN
                  mismatch <= 1'b0;
`endif
               end
            end
            DRIVE: begin
               if (w_expire) begin
                  r_state <= SAMPLE;
               end
            end
            SAMPLE: begin
               tt <= w_tt_final;
               if (r_idx == IDX_LAST) begin
                  r_state  <= DONE;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  dut_in   <= '0;
`ifdef GATE_PROBE_CHECK_EN
                  mismatch <= (w_tt_final != expected);
`endif
               end else begin
                  r_state <= DRIVE;
                  r_idx   <= w_idx_nxt;
                  dut_in  <= w_idx_nxt;
               end
            end
            DONE: begin
               r_state <= IDLE;
               done    <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
               dut_in  <= '0;
            end
         endcase
      end
   end

endmodule
